full_adder: RTL and testbench
=============================

FULL_ADDER -- requirements
Module: full_adder

Interface
Parameters:
REQ-001 The block SHALL have parameter WIDTH, default 1, operand width in bits; legal range 1..32.
REQ-002 The block SHALL have parameter CNT_W, default 8, width of the carry-event counter; legal range 1..16.

Ports:
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous reset, active-high.
REQ-005 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-006 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-007 The block SHALL have port ci, input, 1 bit: carry-in.
REQ-008 The block SHALL have port sum, output, WIDTH bits: combinational sum.
REQ-009 The block SHALL have port co, output, 1 bit: combinational carry-out.
REQ-010 The block SHALL have port sum_q, output, WIDTH bits: registered sum.
REQ-011 The block SHALL have port co_q, output, 1 bit: registered carry-out.
REQ-012 The block SHALL have port co_cnt, output, CNT_W bits: saturating count of clock edges with co=1.

Function
REQ-013 {co, sum} SHALL equal a + b + ci, computed at WIDTH+1 bits, unsigned.
REQ-014 sum and co SHALL be purely combinational: no dependence on clk or rst, settled within the same delta/timestep as an input change.
REQ-015 The adder SHALL be built as a ripple chain of 1-bit cells, one cell per bit: s_i = a_i ^ b_i ^ c_i, c_(i+1) = a_i&b_i | a_i&c_i | b_i&c_i, with c_0 = ci and co = c_WIDTH.
REQ-016 For WIDTH=1, sum and co SHALL follow this truth table (a b ci -> sum co):
- 000->0 0
- 001->1 0
- 010->1 0
- 011->0 1
- 100->1 0
- 101->0 1
- 110->0 1
- 111->1 1
REQ-017 sum_q and co_q SHALL load sum and co on every rising clk edge while rst=0, giving one-cycle latency.
REQ-018 co_cnt SHALL increment by 1 on each rising clk edge where co=1 and rst=0.
REQ-019 co_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-020 The overflow of a+b+ci beyond WIDTH bits SHALL appear only on co; sum SHALL wrap modulo 2^WIDTH.
REQ-021 X/Z on any input SHALL NOT corrupt co_cnt beyond the affected cycle; no other X handling is required.

Reset
REQ-022 Asserting rst SHALL immediately, without waiting for clk, drive sum_q=0, co_q=0 and co_cnt=0.
REQ-023 These registered outputs SHALL hold their reset values while rst=1.
REQ-024 sum and co SHALL remain functional during reset.
REQ-025 Reset deassertion SHALL be synchronized internally so that the first register update occurs on the first full rising edge after rst falls.
REQ-026 Reset asserted mid-count SHALL clear co_cnt with no partial update.

Verification
REQ-027 WIDTH=1, rst=0: apply the 8 combinations of {a,b,ci} in binary order 000..111 at 10 ns intervals -> sum/co match REQ-016 after each step.
REQ-028 After each REQ-027 step, on the next clk edge -> sum_q/co_q equal the previous step's sum/co.
REQ-029 WIDTH=4: a=15, b=0, ci=1 -> sum=0, co=1; a=7, b=8, ci=0 -> sum=15, co=0.
REQ-030 CNT_W=2: hold a=1, b=1, ci=0 for 5 edges -> co_cnt reads 1, 2, 3, 3, 3.
REQ-031 Assert rst asynchronously between edges with co_cnt=2 -> co_cnt=0, sum_q=0, co_q=0 immediately, while sum and co still track the inputs.
REQ-032 Deassert rst with a=1, b=1, ci=1 -> on the first edge after deassertion, sum_q=1, co_q=1, co_cnt=1.

Source files
------------

// File: rtl/full_adder.sv
// full_adder: WIDTH-bit ripple-carry adder with a combinational result,
// a one-cycle registered copy, and a saturating count of carry-out cycles.
module full_adder #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic [WIDTH-1:0] sum_q,
    output logic             co_q,
    output logic [CNT_W-1:0] co_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] sum_c;
    logic             co_c;

    logic [WIDTH-1:0] sum_reg_q;
    logic [WIDTH-1:0] sum_reg_d;
    logic             co_reg_q;
    logic             co_reg_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Ripple chain: one 1-bit full-adder cell per bit, carry passed upward.
    always_comb begin
        logic carry;
        carry = ci;
        sum_c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum_c[i] = a[i] ^ b[i] ^ carry;
            carry    = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
        end
        co_c = carry;
    end

    // Next-state: capture the adder result; bump the carry counter, holding at all-ones.
    always_comb begin
        sum_reg_d = sum_c;
        co_reg_d  = co_c;
        cnt_d     = cnt_q;
        if (co_c && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers; reset clears at once and releases so the very next
    // rising edge after rst falls performs the first load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_reg_q <= '0;
            co_reg_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sum_reg_q <= sum_reg_d;
            co_reg_q  <= co_reg_d;
            cnt_q     <= cnt_d;
        end
    end

    assign sum    = sum_c;
    assign co     = co_c;
    assign sum_q  = sum_reg_q;
    assign co_q   = co_reg_q;
    assign co_cnt = cnt_q;

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: a 1-bit/2-bit-counter instance for the truth table,
// saturation and reset scenarios, and a 4-bit instance for corners and random sums.
module tb_full_adder;

    logic       clk;
    logic       rst;

    logic       a1, b1, ci1;
    logic       sum1, co1, sum1_q, co1_q;
    logic [1:0] cnt1;

    logic [3:0] a4, b4;
    logic       ci4;
    logic [3:0] sum4, sum4_q;
    logic       co4, co4_q;
    logic [7:0] cnt4;

    int n_cmp;
    int n_err;

    full_adder #(.WIDTH(1), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .ci(ci1),
        .sum(sum1), .co(co1), .sum_q(sum1_q), .co_q(co1_q), .co_cnt(cnt1)
    );

    full_adder #(.WIDTH(4), .CNT_W(8)) u_dut4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .ci(ci4),
        .sum(sum4), .co(co4), .sum_q(sum4_q), .co_q(co4_q), .co_cnt(cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Short reset pulse placed away from the rising edge.
    task automatic pulse_reset;
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        logic [4:0] t;
        rst = 1'b1;
        a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1;
        a4 = 4'd7; b4 = 4'd8; ci4 = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (sum1_q !== 1'b0) begin n_err++; $display("FAIL reset_sum1_q got %0b want 0", sum1_q); end
        n_cmp++; if (co1_q !== 1'b0) begin n_err++; $display("FAIL reset_co1_q got %0b want 0", co1_q); end
        n_cmp++; if (cnt1 !== 2'd0) begin n_err++; $display("FAIL reset_cnt1 got %0d want 0", cnt1); end
        n_cmp++; if (sum4_q !== 4'd0) begin n_err++; $display("FAIL reset_sum4_q got %0d want 0", sum4_q); end
        n_cmp++; if (cnt4 !== 8'd0) begin n_err++; $display("FAIL reset_cnt4 got %0d want 0", cnt4); end
        t = 5'(a4) + 5'(b4) + 5'(ci4);
        n_cmp++; if ({co4, sum4} !== t) begin n_err++; $display("FAIL reset_comb4 got %0d want %0d", {co4, sum4}, t); end
        rst = 1'b0;
    endtask

    task automatic test_truth_table;
        int cnt_m;
        logic exp_s, exp_c;
        int total;
        pulse_reset();
        cnt_m = 0;
        for (int i = 0; i < 8; i++) begin
            a1 = i[2]; b1 = i[1]; ci1 = i[0];
            total = i[2] + i[1] + i[0];
            exp_s = (total % 2) == 1;
            exp_c = total >= 2;
            #1;
            n_cmp++; if (sum1 !== exp_s || co1 !== exp_c)
                begin n_err++; $display("FAIL tt_comb[%0d] got s=%0b c=%0b want s=%0b c=%0b", i, sum1, co1, exp_s, exp_c); end
            @(posedge clk);
            if (exp_c && cnt_m < 3) cnt_m++;
            #1;
            n_cmp++; if (sum1_q !== exp_s || co1_q !== exp_c)
                begin n_err++; $display("FAIL tt_reg[%0d] got s=%0b c=%0b want s=%0b c=%0b", i, sum1_q, co1_q, exp_s, exp_c); end
            n_cmp++; if (cnt1 !== 2'(cnt_m))
                begin n_err++; $display("FAIL tt_cnt[%0d] got %0d want %0d", i, cnt1, cnt_m); end
        end
    endtask

    task automatic test_width4_corners;
        a4 = 4'd15; b4 = 4'd0; ci4 = 1'b1; #1;
        n_cmp++; if (sum4 !== 4'd0 || co4 !== 1'b1)
            begin n_err++; $display("FAIL w4_wrap got s=%0d c=%0b want s=0 c=1", sum4, co4); end
        a4 = 4'd7; b4 = 4'd8; ci4 = 1'b0; #1;
        n_cmp++; if (sum4 !== 4'd15 || co4 !== 1'b0)
            begin n_err++; $display("FAIL w4_full got s=%0d c=%0b want s=15 c=0", sum4, co4); end
    endtask

    task automatic test_saturation;
        int exp_seq [5] = '{1, 2, 3, 3, 3};
        pulse_reset();
        a1 = 1'b1; b1 = 1'b1; ci1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (cnt1 !== 2'(exp_seq[i]))
                begin n_err++; $display("FAIL sat_cnt[%0d] got %0d want %0d", i, cnt1, exp_seq[i]); end
        end
    endtask

    task automatic test_async_reset;
        pulse_reset();
        a1 = 1'b1; b1 = 1'b1; ci1 = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        n_cmp++; if (cnt1 !== 2'd2 || co1_q !== 1'b1)
            begin n_err++; $display("FAIL ar_pre got cnt=%0d co_q=%0b want cnt=2 co_q=1", cnt1, co1_q); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (cnt1 !== 2'd0 || sum1_q !== 1'b0 || co1_q !== 1'b0)
            begin n_err++; $display("FAIL ar_clear got cnt=%0d s_q=%0b c_q=%0b want 0 0 0", cnt1, sum1_q, co1_q); end
        a1 = 1'b1; b1 = 1'b0; ci1 = 1'b0; #1;
        n_cmp++; if (sum1 !== 1'b1 || co1 !== 1'b0)
            begin n_err++; $display("FAIL ar_comb got s=%0b c=%0b want s=1 c=0", sum1, co1); end
        a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (cnt1 !== 2'd0 || sum1_q !== 1'b0 || co1_q !== 1'b0)
            begin n_err++; $display("FAIL ar_hold got cnt=%0d s_q=%0b c_q=%0b want 0 0 0", cnt1, sum1_q, co1_q); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (sum1_q !== 1'b1 || co1_q !== 1'b1 || cnt1 !== 2'd1)
            begin n_err++; $display("FAIL ar_release got s_q=%0b c_q=%0b cnt=%0d want 1 1 1", sum1_q, co1_q, cnt1); end
    endtask

    task automatic test_random;
        int cnt_m;
        int total;
        logic [3:0] exp_s;
        logic       exp_c;
        pulse_reset();
        cnt_m = 0;
        for (int i = 0; i < 60; i++) begin
            a4  = 4'($urandom_range(0, 15));
            b4  = 4'($urandom_range(0, 15));
            ci4 = 1'($urandom_range(0, 1));
            total = int'(a4) + int'(b4) + int'(ci4);
            exp_s = 4'(total % 16);
            exp_c = total >= 16;
            #1;
            n_cmp++; if (sum4 !== exp_s || co4 !== exp_c)
                begin n_err++; $display("FAIL rnd_comb[%0d] a=%0d b=%0d ci=%0b got s=%0d c=%0b want s=%0d c=%0b", i, a4, b4, ci4, sum4, co4, exp_s, exp_c); end
            @(posedge clk);
            if (exp_c && cnt_m < 255) cnt_m++;
            #1;
            n_cmp++; if (sum4_q !== exp_s || co4_q !== exp_c || cnt4 !== 8'(cnt_m))
                begin n_err++; $display("FAIL rnd_reg[%0d] got s_q=%0d c_q=%0b cnt=%0d want s_q=%0d c_q=%0b cnt=%0d", i, sum4_q, co4_q, cnt4, exp_s, exp_c, cnt_m); end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        a1 = 1'b0; b1 = 1'b0; ci1 = 1'b0;
        a4 = 4'd0; b4 = 4'd0; ci4 = 1'b0;
        test_reset();
        test_truth_table();
        test_width4_corners();
        test_saturation();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
